// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the bus arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int CPU_ID  = 0;
    localparam int OWNER_W = 3;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between masters and the arbiter
interface bus_arbiter_if import arb_pkg::*; #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic [OWNER_W-1:0] owner;
    logic               busy;
    logic               bus_oe;
    logic               preempt;

    modport master (
        output req, lock,
        input  gnt, owner, busy, bus_oe, preempt
    );

    modport slave (
        input  req, lock,
        output gnt, owner, busy, bus_oe, preempt
    );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - combinational round-robin winner selection
module rr_picker import arb_pkg::*; #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] last,
    input  logic               cpu_prio,
    output logic [NREQ-1:0]    win_oh,
    output logic [OWNER_W-1:0] win_idx,
    output logic               valid
);

    // CPU override first; otherwise scan indices above last, then wrap to 0..last
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        valid   = 1'b0;
        if (cpu_prio && req[CPU_ID]) begin
            win_oh[CPU_ID] = 1'b1;
            win_idx        = OWNER_W'(CPU_ID);
            valid          = 1'b1;
        end else begin
            for (int j = 0; j < NREQ; j++) begin
                if (!valid && req[j] && (OWNER_W'(j) > last)) begin
                    win_oh[j] = 1'b1;
                    win_idx   = OWNER_W'(j);
                    valid     = 1'b1;
                end
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!valid && req[j] && (OWNER_W'(j) <= last)) begin
                    win_oh[j] = 1'b1;
                    win_idx   = OWNER_W'(j);
                    valid     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shared address/data bus arbiter with hold limit and turnaround
module bus_arbiter import arb_pkg::*; #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16,
    parameter int CPU_PRIO = 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    arb_state_t         state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] last_q, last_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               oe_q, oe_d;
    logic               preempt_q, preempt_d;

    logic [NREQ-1:0]    win_oh;
    logic [OWNER_W-1:0] win_idx;
    logic               win_valid;
    logic               owner_req;
    logic               owner_lock;
    logic               others_req;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req      (bus.req),
        .last     (last_q),
        .cpu_prio (CPU_PRIO != 0),
        .win_oh   (win_oh),
        .win_idx  (win_idx),
        .valid    (win_valid)
    );

    // gnt_q is one-hot, so masking with it selects the owner's req/lock bit
    assign owner_req  = |(bus.req & gnt_q);
    assign owner_lock = |(bus.lock & gnt_q);
    assign others_req = |(bus.req & ~gnt_q);

    // Next-state: grant from IDLE/TURN, release or preempt from GRANT
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        oe_d      = oe_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (win_valid) begin
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    oe_d    = 1'b1;
                    state_d = GRANT;
                end else begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    state_d = TURN;
                end else if ((hold_q == HOLD_MAX) && !owner_lock && others_req) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    oe_d      = 1'b0;
                    preempt_d = 1'b1;
                    state_d   = TURN;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                oe_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= OWNER_W'(NREQ - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            oe_q      <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            oe_q      <= oe_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.bus_oe  = oe_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed checks of bus_arbiter against a reference model
module tb_bus_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset_r = 1'b0;
    logic [3:0] req_r = '0;
    logic [3:0] lock_r = '0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    // Reference model, index 0 = round-robin instance, 1 = CPU-priority instance
    int m_owner[2] = '{-1, -1};
    int m_held[2]  = '{0, 0};
    int m_last[2]  = '{3, 3};
    int m_out[2]   = '{0, 0};
    bit m_pre[2]   = '{0, 0};

    always #5 clk = ~clk;

    bus_arbiter_if #(.NREQ(4)) ifa ();
    bus_arbiter_if #(.NREQ(4)) ifb ();

    assign ifa.req  = req_r;
    assign ifa.lock = lock_r;
    assign ifb.req  = req_r;
    assign ifb.lock = lock_r;

    bus_arbiter #(.NREQ(4), .MAX_HOLD(MH), .CPU_PRIO(0)) dut_a (
        .clk   (clk),
        .reset (reset_r),
        .bus   (ifa.slave)
    );

    bus_arbiter #(.NREQ(4), .MAX_HOLD(MH), .CPU_PRIO(1)) dut_b (
        .clk   (clk),
        .reset (reset_r),
        .bus   (ifb.slave)
    );

    function automatic int pick(input int k);
        if (k == 1 && req_r[0]) return 0;
        for (int i = 1; i <= 4; i++) begin
            if (req_r[(m_last[k] + i) % 4]) return (m_last[k] + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input int k);
        int w;
        if (!reset_r) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_last[k]  = 3;
            m_out[k]   = 0;
            m_pre[k]   = 1'b0;
        end else begin
            m_pre[k] = 1'b0;
            if (m_owner[k] >= 0) begin
                if (!req_r[m_owner[k]]) begin
                    m_owner[k] = -1;
                end else if (m_held[k] >= MH - 1 && !lock_r[m_owner[k]] &&
                             (req_r & ~(4'b0001 << m_owner[k])) != 4'b0000) begin
                    m_owner[k] = -1;
                    m_pre[k]   = 1'b1;
                end else begin
                    m_held[k]++;
                end
            end else begin
                w = pick(k);
                if (w >= 0) begin
                    m_owner[k] = w;
                    m_out[k]   = w;
                    m_last[k]  = w;
                    m_held[k]  = 0;
                end
            end
        end
    endtask

    function automatic logic [9:0] expv(input int k);
        logic [3:0] g;
        logic       b;
        g = '0;
        b = (m_owner[k] >= 0);
        if (b) g[m_owner[k]] = 1'b1;
        return {g, b, b, m_pre[k], 3'(m_out[k])};
    endfunction

    function automatic logic [9:0] obs(input int k);
        if (k == 0) return {ifa.gnt, ifa.busy, ifa.bus_oe, ifa.preempt, ifa.owner};
        return {ifb.gnt, ifb.busy, ifb.bus_oe, ifb.preempt, ifb.owner};
    endfunction

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset_r = 1'b0;
        req_r   = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (ifa.gnt !== 4'b0000 || ifb.gnt !== 4'b0000 || ifa.bus_oe !== 1'b0 || ifb.preempt !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d gnt_a=%b gnt_b=%b oe_a=%b want gnt=0000 oe=0", cyc, ifa.gnt, ifb.gnt, ifa.bus_oe);
            end
        end
        reset_r = 1'b1;
        step();
        checks++;
        if (ifa.gnt !== 4'b0001 || ifa.owner !== 3'd0 || ifa.bus_oe !== 1'b1 ||
            ifb.gnt !== 4'b0001 || ifb.owner !== 3'd0 || ifb.bus_oe !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant gnt_a=%b own_a=%0d oe_a=%b gnt_b=%b want gnt=0001 owner=0 oe=1",
                     ifa.gnt, ifa.owner, ifa.bus_oe, ifb.gnt);
        end
    endtask

    task automatic test_alternate();
        logic [3:0] grants[$];
        int         runs[$];
        logic [3:0] prev_g;
        int         zrun;
        req_r = 4'b0000;
        for (int i = 0; i < 2; i++) step();
        req_r  = 4'b0110;
        prev_g = 4'b0000;
        zrun   = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    failures++;
                    $display("FAIL alternate_model inst=%0d cyc=%0d got=%b want=%b", k, cyc, obs(k), expv(k));
                end
            end
            if (ifa.gnt === 4'b0000) begin
                zrun++;
            end else begin
                if (prev_g === 4'b0000) begin
                    grants.push_back(ifa.gnt);
                    if (grants.size() > 1) runs.push_back(zrun);
                end
                zrun = 0;
            end
            prev_g = ifa.gnt;
            if (m_owner[0] >= 0 && m_held[0] == 2) req_r = 4'b0110 & ~(4'b0001 << m_owner[0]);
            else req_r = 4'b0110;
        end
        checks++;
        if (grants.size() < 3) begin
            failures++;
            $display("FAIL alternate_count got=%0d grants want>=3", grants.size());
        end else if ({grants[0], grants[1], grants[2]} !== 12'b0010_0100_0010) begin
            failures++;
            $display("FAIL alternate_order got=%b %b %b want=0010 0100 0010", grants[0], grants[1], grants[2]);
        end
        foreach (runs[i]) begin
            checks++;
            if (runs[i] != 1) begin
                failures++;
                $display("FAIL alternate_turn gap=%0d got=%0d idle cycles want=1", i, runs[i]);
            end
        end
    endtask

    task automatic test_preempt();
        req_r = 4'b0000;
        for (int i = 0; i < 2; i++) step();
        req_r = 4'b0010;
        step();
        checks++;
        if (ifa.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL preempt_grant got=%b want=0010", ifa.gnt);
        end
        req_r = 4'b0110;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (i < 4 && (ifa.gnt !== 4'b0010 || ifa.preempt !== 1'b0)) begin
                failures++;
                $display("FAIL preempt_hold edge=%0d got gnt=%b pre=%b want gnt=0010 pre=0", i, ifa.gnt, ifa.preempt);
            end else if (i == 4 && (ifa.gnt !== 4'b0000 || ifa.preempt !== 1'b1 || ifb.preempt !== 1'b1)) begin
                failures++;
                $display("FAIL preempt_edge got gnt=%b pre_a=%b pre_b=%b want gnt=0000 pre=1", ifa.gnt, ifa.preempt, ifb.preempt);
            end
        end
        step();
        checks++;
        if (ifa.gnt !== 4'b0100 || ifa.preempt !== 1'b0 || obs(1) !== expv(1)) begin
            failures++;
            $display("FAIL preempt_next got gnt=%b pre=%b b=%b want gnt=0100 pre=0 b=%b", ifa.gnt, ifa.preempt, obs(1), expv(1));
        end
    endtask

    task automatic test_lock();
        req_r  = 4'b0000;
        lock_r = 4'b0000;
        for (int i = 0; i < 2; i++) step();
        lock_r = 4'b0010;
        req_r  = 4'b0010;
        step();
        req_r = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (ifa.gnt !== 4'b0010 || ifa.preempt !== 1'b0 || obs(1) !== expv(1)) begin
                failures++;
                $display("FAIL lock_hold cyc=%0d got gnt=%b pre=%b want gnt=0010 pre=0", cyc, ifa.gnt, ifa.preempt);
            end
        end
        req_r = 4'b0100;
        step();
        checks++;
        if (ifa.gnt !== 4'b0000 || ifa.preempt !== 1'b0) begin
            failures++;
            $display("FAIL lock_release got gnt=%b pre=%b want gnt=0000 pre=0", ifa.gnt, ifa.preempt);
        end
        step();
        checks++;
        if (ifa.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL lock_next got=%b want=0100", ifa.gnt);
        end
        lock_r = 4'b0000;
    endtask

    task automatic test_cpu_prio();
        req_r = 4'b0000;
        for (int i = 0; i < 2; i++) step();
        req_r = 4'b1000;
        step();
        req_r = 4'b0001;
        step();
        step();
        checks++;
        if (ifb.gnt !== 4'b0001 || ifa.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL prio_after_3 got b=%b a=%b want 0001 0001", ifb.gnt, ifa.gnt);
        end
        req_r = 4'b1010;
        step();
        req_r = 4'b1011;
        step();
        checks++;
        if (ifb.gnt !== 4'b0001 || ifb.owner !== 3'd0 || ifa.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL prio_over_rr got b=%b own_b=%0d a=%b want b=0001 own_b=0 a=0010", ifb.gnt, ifb.owner, ifa.gnt);
        end
    endtask

    task automatic test_reset_mid();
        req_r = 4'b0000;
        for (int i = 0; i < 2; i++) step();
        req_r = 4'b0100;
        step();
        checks++;
        if (ifa.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL rmid_setup got=%b want=0100", ifa.gnt);
        end
        reset_r = 1'b0;
        step();
        checks++;
        if (ifa.gnt !== 4'b0000 || ifa.bus_oe !== 1'b0 || ifa.preempt !== 1'b0 ||
            ifb.gnt !== 4'b0000 || ifb.bus_oe !== 1'b0 || ifa.owner !== 3'd0) begin
            failures++;
            $display("FAIL rmid_drop got gnt=%b oe=%b pre=%b own=%0d want 0000 0 0 0", ifa.gnt, ifa.bus_oe, ifa.preempt, ifa.owner);
        end
        reset_r = 1'b1;
        step();
        checks++;
        if (ifa.gnt !== 4'b0100 || ifb.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL rmid_regrant got a=%b b=%b want 0100", ifa.gnt, ifb.gnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0) req_r = 4'($urandom);
            lock_r  = 4'($urandom & $urandom & $urandom);
            reset_r = ($urandom_range(0, 59) != 0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    failures++;
                    $display("FAIL random_model inst=%0d cyc=%0d got=%b want=%b", k, cyc, obs(k), expv(k));
                end
            end
            checks++;
            if (!$onehot0(ifa.gnt) || !$onehot0(ifb.gnt) || ifa.bus_oe !== ifa.busy) begin
                failures++;
                $display("FAIL random_invariant cyc=%0d got a=%b b=%b oe=%b busy=%b want onehot0 and oe==busy",
                         cyc, ifa.gnt, ifb.gnt, ifa.bus_oe, ifa.busy);
            end
        end
        reset_r = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_preempt();
        test_lock();
        test_cpu_prio();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
